// File: rtl/decoder_pulse.sv
// decoder_pulse: registered IW-to-2^IW one-hot pulse decoder with PULSE-cycle outputs and done flag.
// Define DECODER_PULSE_PEND_EN to add a one-entry pending request buffer with sticky ovf.
module decoder_pulse #(
  parameter int IW = 3,
  parameter int PULSE = 4,
  localparam int OW = 1 << IW
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          en_,
  input  logic [0:IW-1] i,
  output logic [0:OW-1] o,
  output logic          busy,
  output logic          done,
  output logic          ovf
);
  if (PULSE < 1 || PULSE > 255) begin : g_bad_pulse
    $fatal(1, "decoder_pulse: PULSE must be 1..255");
  end
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_cnt, w_cnt;
  logic [IW-1:0] r_code, w_code, w_sel;
  logic          w_start;
`ifdef DECODER_PULSE_PEND_EN
  logic          r_pv, w_pv, r_ovf;
  logic [IW-1:0] r_pc, w_pc;
  // A queued code always wins over a live request, so any request seen while full is lost.
  assign w_start = (r_state == IDLE) && (r_pv || !en_);
  assign w_sel   = r_pv ? r_pc : i;
  assign busy    = (r_state == ACTIVE) && r_pv;
  assign w_pv    = (r_state == ACTIVE) && (r_pv || !en_);
  assign w_pc    = (r_state == ACTIVE && !r_pv) ? i : r_pc;
  assign ovf     = r_ovf;
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      r_pv  <= 1'b0;
      r_pc  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_pv  <= w_pv;
      r_pc  <= w_pc;
      r_ovf <= r_ovf | (r_pv & ~en_);
    end
`else
  assign w_start = (r_state == IDLE) && !en_;
  assign w_sel   = i;
  assign busy    = (r_state == ACTIVE);
  assign ovf     = 1'b0;
`endif
  always_comb begin
    w_next = (r_state == IDLE) ? (w_start ? ACTIVE : IDLE) : ((r_cnt == 8'd0) ? IDLE : ACTIVE);
    w_cnt  = w_start ? 8'(PULSE - 1) : ((r_state == ACTIVE && r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0);
    w_code = w_start ? w_sel : r_code;
  end
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_code  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_code  <= w_code;
    end
  // Outputs decode straight from state so an async reset clears them without a clock.
  always_comb begin
    o         = '0;
    o[r_code] = (r_state == ACTIVE);
  end
  assign done = (r_state == ACTIVE) && (r_cnt == 8'd0);
endmodule

// File: tb/tb_decoder_pulse.sv
// tb_decoder_pulse: directed checks of decoder_pulse across PULSE=4/1/255 and IW=5 instances.
module tb_decoder_pulse;
`ifdef DECODER_PULSE_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif
  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  always #5 clk_sys = ~clk_sys;
  logic        en0, en1, en2, en3;
  logic [0:2]  i0, i1, i2;
  logic [0:4]  i3;
  logic [0:7]  o0, o1, o2;
  logic [0:31] o3;
  logic busy0, busy1, busy2, busy3, done0, done1, done2, done3, ovf0, ovf1, ovf2, ovf3;
  int checks = 0;
  int errors = 0;
  decoder_pulse #(.IW(3), .PULSE(4)) u0 (.clk_sys(clk_sys), .rst(rst), .en_(en0), .i(i0), .o(o0), .busy(busy0), .done(done0), .ovf(ovf0));
  decoder_pulse #(.IW(3), .PULSE(1)) u1 (.clk_sys(clk_sys), .rst(rst), .en_(en1), .i(i1), .o(o1), .busy(busy1), .done(done1), .ovf(ovf1));
  decoder_pulse #(.IW(3), .PULSE(255)) u2 (.clk_sys(clk_sys), .rst(rst), .en_(en2), .i(i2), .o(o2), .busy(busy2), .done(done2), .ovf(ovf2));
  decoder_pulse #(.IW(5), .PULSE(4)) u3 (.clk_sys(clk_sys), .rst(rst), .en_(en3), .i(i3), .o(o3), .busy(busy3), .done(done3), .ovf(ovf3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  initial begin
    int bad;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;
    tick;
    chk("rst_o", {24'd0, o0}, 32'd0);
    chk("rst_flags", {busy0, done0, ovf0}, 32'd0);
    rst = 1'b0;
    tick;
    // single request on code 5; i changes mid-pulse must not matter
    en0 = 1'b0; i0 = 3'd5;
    tick;
    en0 = 1'b1; i0 = 3'd0;
    for (int k = 0; k < 4; k++) begin
      chk("single_o", {24'd0, o0}, 32'b00000100);
      chk("single_busy", {31'd0, busy0}, 32'd1);
      chk("single_done", {31'd0, done0}, (k == 3) ? 32'd1 : 32'd0);
      tick;
    end
    chk("single_end", {24'd0, o0, busy0, done0}, 32'd0);
    // back-to-back with en_ held low
    en0 = 1'b0; i0 = 3'd1;
    tick;
    i0 = 3'd6;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_o1", {24'd0, o0}, 32'b01000000);
      tick;
    end
    chk("b2b_gap", {24'd0, o0}, 32'd0);
    tick;
    en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_o6", {24'd0, o0}, 32'b00000010);
      tick;
    end
    chk("b2b_end", {24'd0, o0}, 32'd0);
    // async reset during second cycle of a pulse
    en0 = 1'b0; i0 = 3'd2;
    tick;
    en0 = 1'b1;
    tick;
    chk("prerst_o", {24'd0, o0}, 32'b00100000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {24'd0, o0, busy0, done0, ovf0}, 32'd0);
    rst = 1'b0;
    en0 = 1'b0; i0 = 3'd3;
    tick;
    en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("postrst_o", {24'd0, o0}, 32'b00010000);
      tick;
    end
    chk("postrst_end", {24'd0, o0}, 32'd0);
    // requests during a pulse: queued (7) and dropped (4) with the buffer, ignored without
    en0 = 1'b0; i0 = 3'd2;
    tick;
    i0 = 3'd7;
    tick;
    i0 = 3'd4;
    tick;
    en0 = 1'b1;
    chk("pend_o2", {24'd0, o0}, 32'b00100000);
    chk("pend_busy", {31'd0, busy0}, 32'd1);
    chk("pend_ovf", {31'd0, ovf0}, PEND ? 32'd1 : 32'd0);
    tick;
    chk("pend_done", {31'd0, done0}, 32'd1);
    tick;
    chk("pend_gap", {24'd0, o0}, 32'd0);
    tick;
    chk("pend_next", {24'd0, o0}, PEND ? 32'b00000001 : 32'd0);
    for (int k = 0; k < 4; k++) tick;
    chk("pend_end", {24'd0, o0, ovf0}, PEND ? 32'd1 : 32'd0);
    // PULSE = 1
    en1 = 1'b0; i1 = 3'd0;
    tick;
    en1 = 1'b1;
    chk("p1_o", {24'd0, o1}, 32'b10000000);
    chk("p1_done_busy", {30'd0, done1, busy1}, 32'd3);
    tick;
    chk("p1_end", {24'd0, o1, done1}, 32'd0);
    // PULSE = 255
    en2 = 1'b0; i2 = 3'd0;
    tick;
    en2 = 1'b1;
    bad = 0;
    for (int k = 0; k < 255; k++) begin
      if (o2 !== 8'b10000000 || done2 !== (k == 254)) bad++;
      tick;
    end
    chk("p255_pulse", bad, 32'd0);
    chk("p255_end", {24'd0, o2, done2}, 32'd0);
    // IW = 5 sweep
    for (int c = 0; c < 32; c++) begin
      en3 = 1'b0; i3 = 5'(c);
      tick;
      en3 = 1'b1;
      chk("iw5_onehot", o3, 32'h80000000 >> c);
      for (int k = 0; k < 4; k++) tick;
    end
    chk("iw5_end", o3, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_pulse.md
# decoder_pulse

Parametrised, registered successor of the combinational 3-to-8 decoder. It captures an IW-bit select code on an active-low request strobe and drives the matching one of 2^IW one-hot outputs for a programmable number of clock cycles, then reports completion. It sits between microcode or control sequencing and the timed control lines, such as register strobes and bus-cycle enables, that need a guaranteed minimum width and a guaranteed gap between pulses.

## Interface
- IW, default 3: select width; output count OW = 2^IW (derived, not overridable).
- PULSE, default 4: output pulse length in clock cycles; valid range 1..255; PULSE=0 fails elaboration.
- clk_sys, input, 1: system clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en_, input, 1: active-low request strobe, sampled on clk_sys.
- i, input, [0:IW-1]: select code; i[0] is the MSB.
- o, output, [0:OW-1]: one-hot pulse outputs; o[n] corresponds to code n.
- busy, output, 1: request not accepted this cycle (see Operation).
- done, output, 1: high during the last cycle of each pulse.
- ovf, output, 1: sticky dropped-request flag (constant 0 without the macro).

## Operation
- Reset values: o = 0, busy = 0, done = 0, ovf = 0, FSM = IDLE, counter = 0, pending entry empty.
- State IDLE:
  - If en_ = 0 at a clock edge, latch i, load counter with PULSE-1, and go to ACTIVE.
  - While in IDLE, o = 0 and busy = 0.
- State ACTIVE:
  - o[code] = 1; all other bits are 0.
  - Counter decrements each cycle.
  - When counter = 0: done = 1 for that cycle; next edge returns to IDLE and clears o.
- Exactly one bit of o is set in ACTIVE; no bit is set in IDLE.
- Latched code is stable for the whole pulse; changes on i during ACTIVE have no effect.
- Requests with en_ = 0 while in ACTIVE (without macro): ignored. busy = 1 for the whole of ACTIVE.
- IDLE with a valid pending entry (macro only): behaves as if en_ = 0 with the pending code. The pending entry takes priority over a simultaneous live request; that live request is dropped and sets ovf.

## Timing
- Request sampled at edge k:
  - o asserted from edge k+1.
  - o deasserted at edge k+1+PULSE.
  - done high between edges k+PULSE and k+1+PULSE.
- Latency from request to output is 1 cycle; pulse width is exactly PULSE cycles.
- Earliest next accepted request is at edge k+1+PULSE, which gives o asserted at k+2+PULSE.
- Minimum all-zero gap between consecutive pulses is 1 cycle. This holds for back-to-back and pending-fed pulses alike.
- PULSE = 1: o high for a single cycle with done high in the same cycle.
- rst asserted mid-pulse: o, done, busy and pending are cleared immediately, without waiting for clk_sys. The first request is accepted at the first edge after rst deasserts.

## Configuration
- DECODER_PULSE_PEND_EN defined: a one-entry pending buffer is added.
  - The first request (en_ = 0) seen while in ACTIVE with the buffer empty is stored.
  - busy = 1 only when in ACTIVE and the buffer is full.
  - A request while busy = 1 is dropped and sets ovf = 1 until rst.
  - The pending request issues after the mandatory 1-cycle gap.
- DECODER_PULSE_PEND_EN undefined: no buffer exists.
  - busy = 1 throughout ACTIVE.
  - Requests during ACTIVE are silently ignored; ovf is tied 0.

## Test plan
- Single request: IW = 3, PULSE = 4; en_ low for 1 cycle with i = 5 at edge 10 -> o = 8'b00000100 (o[5]) from edge 11 to 15; done high in cycle 14–15; busy high for cycles 11–15.
- Back-to-back requests: en_ held low with i = 1, then i = 6 -> pulses on o[1] and o[6], each 4 cycles, separated by exactly one cycle of o = 0; no cycle has two bits set.
- PULSE = 1 and PULSE = 255: request with i = 0 -> o[0] high for 1 cycle and 255 cycles respectively; done coincides with the last high cycle.
- Reset mid-pulse: rst pulse at cycle 2 of a pulse -> o = 0 immediately (asynchronously); a request with i = 3 after reset release -> normal 4-cycle pulse on o[3].
- Macro enabled, with the first pulse on i = 2:
  - Request i = 7 during the pulse -> o[7] pulse follows after a 1-cycle gap.
  - A further request (i = 4) during the same pulse -> busy = 1, request dropped, ovf = 1, and no o[4] pulse.
  - Macro disabled, same stimulus -> only the o[2] pulse is produced and ovf stays 0.
- Width generalisation: IW = 5, sweep i = 0..31 -> each code asserts only o[i]; all 32 outputs are checked for one-hot correctness.
